axi_tb_arbiter: RTL and testbench
=================================

Name: axi_tb_arbiter

Overview:
Two-master to one-slave AXI4 arbiter for the testbench memory/UART model. It lets two masters (m0 = LSU, m1 = IFU/DMA) share the single testbench AXI slave. Read and write channels are arbitrated independently with round-robin fairness and one outstanding transaction per channel. The slave ID is widened by one bit so that responses can be routed back and checked.

Parameters:
TAGW, 4, master-side ID width; slave-side ID width is TAGW+1
TIMEOUT, 1024, cycles allowed waiting for R/B response before err is flagged

Ports:
aclk  in  1  clock
rst  in  1  synchronous active-high reset
m{0,1}_arvalid/arready  in/out  1  read address handshake
m{0,1}_araddr, arid, arlen, arburst, arsize  in  32, TAGW, 8, 2, 3  read address fields
m{0,1}_rvalid, rdata, rresp, rid, rlast / rready  out/in  1, 64, 2, TAGW, 1 / 1  read data channel
m{0,1}_awvalid/awready  in/out  1  write address handshake
m{0,1}_awaddr, awid, awlen, awburst, awsize  in  32, TAGW, 8, 2, 3  write address fields
m{0,1}_wvalid, wdata, wstrb / wready  in / out  1, 64, 8 / 1  write data channel
m{0,1}_bvalid, bresp, bid / bready  out / in  1, 2, TAGW / 1  write response channel
s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored  as master side; s_arid/s_rid/s_awid/s_bid are TAGW+1  slave port
err  out  1  sticky protocol/timeout error

Behaviour:
- Reset (rst high at posedge):
  - FSMs go to IDLE; both priority pointers go to 0 (m0 favoured); err goes to 0.
  - All valid/ready outputs (master and slave side) are 0 from that edge on.
  - Any in-flight transaction is abandoned; masters are reset by the same signal.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: if either m*_arvalid is set, the rr_grant picks a winner and latches rd_gnt; next state R_ADDR. Latency from arvalid to s_arvalid is 1 cycle.
  - R_ADDR: s_ar* carries the granted master's fields; s_arid = {rd_gnt, m_arid}; the granted m_arready = s_arready. On s_arvalid && s_arready, go to R_DATA.
  - R_DATA: s_r* is routed to the granted master; m_rid = s_rid[TAGW-1:0]; s_rready = granted m_rready. On a beat with rvalid && rready && rlast, go to R_IDLE and set the pointer to the non-winner.
  - In R_DATA, s_rid[TAGW] != rd_gnt sets err.
- Write FSM, states W_IDLE, W_ADDR, W_RESP:
  - Arbitration is the same as for reads, using its own pointer.
  - W_ADDR: the slave samples AW and W together. s_awvalid = s_wvalid = m_awvalid && m_wvalid of the granted master. The granted m_awready = m_wready = s_awready && s_wready && both valid.
  - On that handshake, go to W_RESP. If awlen != 0 at handshake, set err (single-beat writes only).
  - W_RESP: route B to the winner, strip bid[TAGW]. On bvalid && bready, go to W_IDLE and flip the pointer.
- Non-granted master always sees ready=0, valid=0 and data outputs 0. The slave side drives 0 on fields when the channel is in IDLE.
- Simultaneous requests: the master at the pointer wins. Read and write are fully independent, so both may be active in the same cycle.
- Starvation bound: a waiting master is granted after at most one transaction by the other master.
- Timeout: a per-channel counter, reset on entering R_DATA/W_RESP, increments each cycle in that state. Reaching TIMEOUT sets err; the FSM keeps waiting. The counter saturates and does not wrap.
- Master deasserting valid before handshake in ADDR: the grant is held and is not re-arbitrated.

Decomposition:
- Package axi_tb_arb_pkg holds:
  - rd_state_t {R_IDLE, R_ADDR, R_DATA}
  - wr_state_t {W_IDLE, W_ADDR, W_RESP}
  - NUM_M=2
  - AXI_RESP_OKAY=2'b00
- Sub-module axi_tb_rr_grant: 2-request round-robin picker plus pointer register, with ports req[1:0], advance, gnt_idx. It is instantiated once for read and once for write.

Test Plan:
- m0 only: read araddr=0x100, arid=3 -> s_arid=5'h03 one cycle later; m0_rdata = slave data, m0_rid=3, rlast=1; m1 sees rvalid=0 throughout.
- m0 and m1 arvalid together after reset -> m0 granted first (s_arid[4]=0), then m1 (s_arid[4]=1). A repeated simultaneous pair then alternates m1, m0.
- Concurrent m0 write (awaddr=0x200, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF) and m1 read of 0x200 -> both channels proceed in the same cycles. A subsequent m1 read of 0x200 returns 0xDEADBEEFCAFEF00D.
- Slave withholds bvalid for TIMEOUT cycles -> err rises on cycle TIMEOUT and stays high; a later bvalid completes the transaction normally.
- rst pulsed for one cycle while the read FSM is in R_DATA -> next cycle all valids/readies are 0, FSM is R_IDLE, err=0, pointer=0; a new m1 request is granted normally.
- m1 write with awlen=3 -> err=1 after the handshake; B is still routed to m1 with bid equal to the original awid.

Source files
------------

// File: rtl/axi_tb_arb_pkg.sv
// Shared types and helpers for the two-master testbench AXI arbiter.
package axi_tb_arb_pkg;
  localparam int NUM_M = 2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

  // One-hot master select, all-zero when the channel phase is inactive.
  function automatic logic [NUM_M-1:0] sel_oh(input logic idx, input logic en);
    sel_oh = '0;
    if (en) sel_oh[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/axi_tb_rr_grant.sv
// Two-request round-robin picker; pointer moves to the loser when a transaction retires.
module axi_tb_rr_grant
  import axi_tb_arb_pkg::*;
(
  input  logic             aclk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req,
  input  logic             advance,
  input  logic             done_idx,
  output logic             gnt_idx
);
  logic ptr;

  always_comb gnt_idx = req[ptr] ? ptr : ~ptr;

  always_ff @(posedge aclk) begin
    if (rst)          ptr <= 1'b0;
    else if (advance) ptr <= ~done_idx;
  end
endmodule

// File: rtl/axi_tb_arbiter.sv
// Two-master to one-slave AXI4 arbiter; independent read/write channels, one outstanding each.
module axi_tb_arbiter
  import axi_tb_arb_pkg::*;
#(
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            m0_arvalid, m1_arvalid,
  output logic            m0_arready, m1_arready,
  input  logic [31:0]     m0_araddr, m1_araddr,
  input  logic [TAGW-1:0] m0_arid, m1_arid,
  input  logic [7:0]      m0_arlen, m1_arlen,
  input  logic [1:0]      m0_arburst, m1_arburst,
  input  logic [2:0]      m0_arsize, m1_arsize,
  output logic            m0_rvalid, m1_rvalid,
  output logic [63:0]     m0_rdata, m1_rdata,
  output logic [1:0]      m0_rresp, m1_rresp,
  output logic [TAGW-1:0] m0_rid, m1_rid,
  output logic            m0_rlast, m1_rlast,
  input  logic            m0_rready, m1_rready,
  input  logic            m0_awvalid, m1_awvalid,
  output logic            m0_awready, m1_awready,
  input  logic [31:0]     m0_awaddr, m1_awaddr,
  input  logic [TAGW-1:0] m0_awid, m1_awid,
  input  logic [7:0]      m0_awlen, m1_awlen,
  input  logic [1:0]      m0_awburst, m1_awburst,
  input  logic [2:0]      m0_awsize, m1_awsize,
  input  logic            m0_wvalid, m1_wvalid,
  input  logic [63:0]     m0_wdata, m1_wdata,
  input  logic [7:0]      m0_wstrb, m1_wstrb,
  output logic            m0_wready, m1_wready,
  output logic            m0_bvalid, m1_bvalid,
  output logic [1:0]      m0_bresp, m1_bresp,
  output logic [TAGW-1:0] m0_bid, m1_bid,
  input  logic            m0_bready, m1_bready,
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [31:0]     s_araddr,
  output logic [TAGW:0]   s_arid,
  output logic [7:0]      s_arlen,
  output logic [1:0]      s_arburst,
  output logic [2:0]      s_arsize,
  input  logic            s_rvalid,
  input  logic [63:0]     s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic [TAGW:0]   s_rid,
  input  logic            s_rlast,
  output logic            s_rready,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [31:0]     s_awaddr,
  output logic [TAGW:0]   s_awid,
  output logic [7:0]      s_awlen,
  output logic [1:0]      s_awburst,
  output logic [2:0]      s_awsize,
  output logic            s_wvalid,
  output logic [63:0]     s_wdata,
  output logic [7:0]      s_wstrb,
  input  logic            s_wready,
  input  logic            s_bvalid,
  input  logic [1:0]      s_bresp,
  input  logic [TAGW:0]   s_bid,
  output logic            s_bready,
  output logic            err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [NUM_M-1:0]           m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [NUM_M-1:0][31:0]     m_araddr, m_awaddr;
  logic [NUM_M-1:0][TAGW-1:0] m_arid, m_awid;
  logic [NUM_M-1:0][7:0]      m_arlen, m_awlen, m_wstrb;
  logic [NUM_M-1:0][1:0]      m_arburst, m_awburst;
  logic [NUM_M-1:0][2:0]      m_arsize, m_awsize;
  logic [NUM_M-1:0][63:0]     m_wdata;

  assign m_arvalid = {m1_arvalid, m0_arvalid};  assign m_rready  = {m1_rready, m0_rready};
  assign m_awvalid = {m1_awvalid, m0_awvalid};  assign m_wvalid  = {m1_wvalid, m0_wvalid};
  assign m_bready  = {m1_bready, m0_bready};
  assign m_araddr  = {m1_araddr, m0_araddr};    assign m_awaddr  = {m1_awaddr, m0_awaddr};
  assign m_arid    = {m1_arid, m0_arid};        assign m_awid    = {m1_awid, m0_awid};
  assign m_arlen   = {m1_arlen, m0_arlen};      assign m_awlen   = {m1_awlen, m0_awlen};
  assign m_arburst = {m1_arburst, m0_arburst};  assign m_awburst = {m1_awburst, m0_awburst};
  assign m_arsize  = {m1_arsize, m0_arsize};    assign m_awsize  = {m1_awsize, m0_awsize};
  assign m_wdata   = {m1_wdata, m0_wdata};      assign m_wstrb   = {m1_wstrb, m0_wstrb};

  rd_state_t rd_st, rd_nxt;
  wr_state_t wr_st, wr_nxt;
  logic rd_gnt, rd_pick, wr_gnt, wr_pick;
  logic ar_hs, aw_hs, rd_done, wr_done, wr_go, err_set;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic [NUM_M-1:0] ar_sel, r_sel, aw_sel, b_sel;

  assign ar_hs   = s_arvalid & s_arready;
  assign rd_done = (rd_st == R_DATA) & s_rvalid & s_rready & s_rlast;
  assign wr_go   = m_awvalid[wr_gnt] & m_wvalid[wr_gnt];
  assign aw_hs   = s_awvalid & s_awready & s_wready;
  assign wr_done = (wr_st == W_RESP) & s_bvalid & s_bready;

  axi_tb_rr_grant u_rd_arb (.aclk, .rst, .req(m_arvalid), .advance(rd_done),
                            .done_idx(rd_gnt), .gnt_idx(rd_pick));
  axi_tb_rr_grant u_wr_arb (.aclk, .rst, .req(m_awvalid), .advance(wr_done),
                            .done_idx(wr_gnt), .gnt_idx(wr_pick));

  always_comb begin
    rd_nxt = rd_st;
    wr_nxt = wr_st;
    unique case (rd_st)
      R_IDLE:  if (|m_arvalid) rd_nxt = R_ADDR;
      R_ADDR:  if (ar_hs)      rd_nxt = R_DATA;
      R_DATA:  if (rd_done)    rd_nxt = R_IDLE;
      default: rd_nxt = R_IDLE;
    endcase
    unique case (wr_st)
      W_IDLE:  if (|m_awvalid) wr_nxt = W_ADDR;
      W_ADDR:  if (aw_hs)      wr_nxt = W_RESP;
      W_RESP:  if (wr_done)    wr_nxt = W_IDLE;
      default: wr_nxt = W_IDLE;
    endcase
  end

  // Tag mismatch, multi-beat write, or a wait that is about to reach TIMEOUT.
  assign err_set = ((rd_st == R_DATA) & s_rvalid & (s_rid[TAGW] != rd_gnt))
                 | ((rd_st == R_DATA) & (rd_cnt == CW'(TIMEOUT - 1)))
                 | ((wr_st == W_ADDR) & aw_hs & (|m_awlen[wr_gnt]))
                 | ((wr_st == W_RESP) & s_bvalid & (s_bid[TAGW] != wr_gnt))
                 | ((wr_st == W_RESP) & (wr_cnt == CW'(TIMEOUT - 1)));

  always_ff @(posedge aclk) begin
    if (rst) begin
      rd_st  <= R_IDLE;
      wr_st  <= W_IDLE;
      rd_gnt <= 1'b0;
      wr_gnt <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      rd_st <= rd_nxt;
      wr_st <= wr_nxt;
      if (rd_st == R_IDLE && |m_arvalid) rd_gnt <= rd_pick;
      if (wr_st == W_IDLE && |m_awvalid) wr_gnt <= wr_pick;
      if (rd_st != R_DATA)              rd_cnt <= '0;
      else if (rd_cnt != CW'(TIMEOUT))  rd_cnt <= rd_cnt + 1'b1;
      if (wr_st != W_RESP)              wr_cnt <= '0;
      else if (wr_cnt != CW'(TIMEOUT))  wr_cnt <= wr_cnt + 1'b1;
      err <= err | err_set;
    end
  end

  assign ar_sel = sel_oh(rd_gnt, rd_st == R_ADDR);
  assign r_sel  = sel_oh(rd_gnt, rd_st == R_DATA);
  assign aw_sel = sel_oh(wr_gnt, wr_st == W_ADDR);
  assign b_sel  = sel_oh(wr_gnt, wr_st == W_RESP);

  // Slave side: fields follow the held grant outside IDLE, zero otherwise.
  assign s_arvalid = ar_sel[rd_gnt] & m_arvalid[rd_gnt];
  assign s_araddr  = (rd_st != R_IDLE) ? m_araddr[rd_gnt]       : '0;
  assign s_arid    = (rd_st != R_IDLE) ? {rd_gnt, m_arid[rd_gnt]} : '0;
  assign s_arlen   = (rd_st != R_IDLE) ? m_arlen[rd_gnt]        : '0;
  assign s_arburst = (rd_st != R_IDLE) ? m_arburst[rd_gnt]      : '0;
  assign s_arsize  = (rd_st != R_IDLE) ? m_arsize[rd_gnt]       : '0;
  assign s_rready  = r_sel[rd_gnt] & m_rready[rd_gnt];

  assign s_awvalid = aw_sel[wr_gnt] & wr_go;
  assign s_wvalid  = s_awvalid;
  assign s_awaddr  = (wr_st != W_IDLE) ? m_awaddr[wr_gnt]       : '0;
  assign s_awid    = (wr_st != W_IDLE) ? {wr_gnt, m_awid[wr_gnt]} : '0;
  assign s_awlen   = (wr_st != W_IDLE) ? m_awlen[wr_gnt]        : '0;
  assign s_awburst = (wr_st != W_IDLE) ? m_awburst[wr_gnt]      : '0;
  assign s_awsize  = (wr_st != W_IDLE) ? m_awsize[wr_gnt]       : '0;
  assign s_wdata   = (wr_st != W_IDLE) ? m_wdata[wr_gnt]        : '0;
  assign s_wstrb   = (wr_st != W_IDLE) ? m_wstrb[wr_gnt]        : '0;
  assign s_bready  = b_sel[wr_gnt] & m_bready[wr_gnt];

  assign m0_arready = ar_sel[0] & s_arready;
  assign m1_arready = ar_sel[1] & s_arready;
  assign m0_rvalid  = r_sel[0] & s_rvalid;
  assign m1_rvalid  = r_sel[1] & s_rvalid;
  assign m0_rdata   = r_sel[0] ? s_rdata : '0;
  assign m1_rdata   = r_sel[1] ? s_rdata : '0;
  assign m0_rresp   = r_sel[0] ? s_rresp : AXI_RESP_OKAY;
  assign m1_rresp   = r_sel[1] ? s_rresp : AXI_RESP_OKAY;
  assign m0_rid     = r_sel[0] ? s_rid[TAGW-1:0] : '0;
  assign m1_rid     = r_sel[1] ? s_rid[TAGW-1:0] : '0;
  assign m0_rlast   = r_sel[0] & s_rlast;
  assign m1_rlast   = r_sel[1] & s_rlast;

  assign m0_awready = aw_sel[0] & wr_go & s_awready & s_wready;
  assign m1_awready = aw_sel[1] & wr_go & s_awready & s_wready;
  assign m0_wready  = m0_awready;
  assign m1_wready  = m1_awready;
  assign m0_bvalid  = b_sel[0] & s_bvalid;
  assign m1_bvalid  = b_sel[1] & s_bvalid;
  assign m0_bresp   = b_sel[0] ? s_bresp : AXI_RESP_OKAY;
  assign m1_bresp   = b_sel[1] ? s_bresp : AXI_RESP_OKAY;
  assign m0_bid     = b_sel[0] ? s_bid[TAGW-1:0] : '0;
  assign m1_bid     = b_sel[1] ? s_bid[TAGW-1:0] : '0;
endmodule

// File: tb/tb_axi_tb_arbiter.sv
// Directed bench for axi_tb_arbiter with a reactive single-outstanding slave model.
module tb_axi_tb_arbiter;
  localparam int TAGW    = 4;
  localparam int TIMEOUT = 16;

  logic aclk, rst;
  logic            m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0]     m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
  logic [TAGW-1:0] m0_arid, m1_arid, m0_rid, m1_rid, m0_awid, m1_awid, m0_bid, m1_bid;
  logic [7:0]      m0_arlen, m1_arlen, m0_awlen, m1_awlen, m0_wstrb, m1_wstrb;
  logic [1:0]      m0_arburst, m1_arburst, m0_awburst, m1_awburst;
  logic [2:0]      m0_arsize, m1_arsize, m0_awsize, m1_awsize;
  logic            m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [63:0]     m0_rdata, m1_rdata, m0_wdata, m1_wdata;
  logic [1:0]      m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic            m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic            m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic            m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic            s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0]     s_araddr, s_awaddr;
  logic [TAGW:0]   s_arid, s_rid, s_awid, s_bid;
  logic [7:0]      s_arlen, s_awlen, s_wstrb;
  logic [1:0]      s_arburst, s_awburst, s_rresp, s_bresp;
  logic [2:0]      s_arsize, s_awsize;
  logic [63:0]     s_rdata, s_wdata;
  logic            err;

  int checks = 0;
  int errs   = 0;
  logic hold_b;

  axi_tb_arbiter #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m1_arvalid(m1_arvalid), .m0_arready(m0_arready), .m1_arready(m1_arready),
    .m0_araddr(m0_araddr), .m1_araddr(m1_araddr), .m0_arid(m0_arid), .m1_arid(m1_arid),
    .m0_arlen(m0_arlen), .m1_arlen(m1_arlen), .m0_arburst(m0_arburst), .m1_arburst(m1_arburst),
    .m0_arsize(m0_arsize), .m1_arsize(m1_arsize),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rresp(m0_rresp), .m1_rresp(m1_rresp), .m0_rid(m0_rid), .m1_rid(m1_rid),
    .m0_rlast(m0_rlast), .m1_rlast(m1_rlast), .m0_rready(m0_rready), .m1_rready(m1_rready),
    .m0_awvalid(m0_awvalid), .m1_awvalid(m1_awvalid), .m0_awready(m0_awready), .m1_awready(m1_awready),
    .m0_awaddr(m0_awaddr), .m1_awaddr(m1_awaddr), .m0_awid(m0_awid), .m1_awid(m1_awid),
    .m0_awlen(m0_awlen), .m1_awlen(m1_awlen), .m0_awburst(m0_awburst), .m1_awburst(m1_awburst),
    .m0_awsize(m0_awsize), .m1_awsize(m1_awsize),
    .m0_wvalid(m0_wvalid), .m1_wvalid(m1_wvalid), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wstrb(m0_wstrb), .m1_wstrb(m1_wstrb), .m0_wready(m0_wready), .m1_wready(m1_wready),
    .m0_bvalid(m0_bvalid), .m1_bvalid(m1_bvalid), .m0_bresp(m0_bresp), .m1_bresp(m1_bresp),
    .m0_bid(m0_bid), .m1_bid(m1_bid), .m0_bready(m0_bready), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
    .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave: memory preset to {A5A50000, word index}; R one cycle after AR, B after AW/W unless held.
  logic [63:0]   mem [0:127];
  logic [TAGW:0] bq_id;
  logic          b_pend;
  logic [7:0]    r_left;
  always @(posedge aclk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= {32'hA5A5_0000, 32'(i)};
      s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= '0; s_rid <= '0; r_left <= '0;
      s_bvalid <= 1'b0; s_bid <= '0; bq_id <= '0; b_pend <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1; s_rid <= s_arid; s_rdata <= mem[s_araddr[9:3]];
        s_rlast <= (s_arlen == 8'd0); r_left <= s_arlen;
      end else if (s_rvalid && s_rready) begin
        if (s_rlast) s_rvalid <= 1'b0;
        else begin r_left <= r_left - 8'd1; s_rlast <= (r_left == 8'd1); s_rdata <= s_rdata + 64'd1; end
      end
      if (s_awvalid && s_awready && s_wvalid && s_wready) begin
        mem[s_awaddr[9:3]] <= s_wdata; bq_id <= s_awid;
        if (hold_b) b_pend <= 1'b1;
        else begin s_bvalid <= 1'b1; s_bid <= s_awid; end
      end else if (b_pend && !hold_b) begin
        s_bvalid <= 1'b1; s_bid <= bq_id; b_pend <= 1'b0;
      end else if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ar_drive(input logic m, input logic v, input logic [31:0] a,
                          input logic [TAGW-1:0] id, input logic [7:0] len);
    if (!m) begin m0_arvalid = v; m0_araddr = a; m0_arid = id; m0_arlen = len; end
    else    begin m1_arvalid = v; m1_araddr = a; m1_arid = id; m1_arlen = len; end
  endtask

  task automatic aw_drive(input logic m, input logic v, input logic [31:0] a,
                          input logic [TAGW-1:0] id, input logic [7:0] len, input logic [63:0] d);
    if (!m) begin m0_awvalid = v; m0_wvalid = v; m0_awaddr = a; m0_awid = id; m0_awlen = len; m0_wdata = d; end
    else    begin m1_awvalid = v; m1_wvalid = v; m1_awaddr = a; m1_awid = id; m1_awlen = len; m1_wdata = d; end
  endtask

  // Wait for the AR grant, check routing, then check the single R beat reaches only master m.
  task automatic rd_grant(input string tag, input logic m, input logic [TAGW-1:0] id,
                          input logic [63:0] d, output int lat);
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!s_arvalid && lat < 40);
    chk({tag, ".arvalid"}, 64'(s_arvalid), 64'(1));
    chk({tag, ".arid"}, 64'(s_arid), 64'({m, id}));
    chk({tag, ".arready"}, 64'(m ? m1_arready : m0_arready), 64'(1));
    chk({tag, ".arready_other"}, 64'(m ? m0_arready : m1_arready), 64'(0));
    @(negedge aclk);
    ar_drive(m, 1'b0, 32'h0, '0, 8'h0);
    chk({tag, ".rvalid"}, 64'(m ? m1_rvalid : m0_rvalid), 64'(1));
    chk({tag, ".rdata"}, m ? m1_rdata : m0_rdata, d);
    chk({tag, ".rid"}, 64'(m ? m1_rid : m0_rid), 64'(id));
    chk({tag, ".rlast"}, 64'(m ? m1_rlast : m0_rlast), 64'(1));
    chk({tag, ".rvalid_other"}, 64'(m ? m0_rvalid : m1_rvalid), 64'(0));
    @(negedge aclk);
  endtask

  task automatic wr_grant(input string tag, input logic m, input logic [TAGW-1:0] id, input logic exp_err);
    int n = 0;
    do begin @(negedge aclk); n++; end while (!s_awvalid && n < 40);
    chk({tag, ".awvalid"}, 64'(s_awvalid), 64'(1));
    chk({tag, ".awid"}, 64'(s_awid), 64'({m, id}));
    chk({tag, ".awready"}, 64'(m ? m1_awready : m0_awready), 64'(1));
    chk({tag, ".awready_other"}, 64'(m ? m0_awready : m1_awready), 64'(0));
    @(negedge aclk);
    aw_drive(m, 1'b0, 32'h0, '0, 8'h0, 64'h0);
    chk({tag, ".err"}, 64'(err), 64'(exp_err));
    chk({tag, ".bvalid"}, 64'(m ? m1_bvalid : m0_bvalid), 64'(1));
    chk({tag, ".bid"}, 64'(m ? m1_bid : m0_bid), 64'(id));
    @(negedge aclk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; hold_b = 1'b0;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_rresp = 2'b00; s_bresp = 2'b00;
    ar_drive(1'b0, 1'b0, 32'h0, '0, 8'h0); ar_drive(1'b1, 1'b0, 32'h0, '0, 8'h0);
    aw_drive(1'b0, 1'b0, 32'h0, '0, 8'h0, 64'h0); aw_drive(1'b1, 1'b0, 32'h0, '0, 8'h0, 64'h0);
    m0_arburst = 2'b01; m1_arburst = 2'b01; m0_awburst = 2'b01; m1_awburst = 2'b01;
    m0_arsize = 3'b011; m1_arsize = 3'b011; m0_awsize = 3'b011; m1_awsize = 3'b011;
    m0_wstrb = 8'hFF; m1_wstrb = 8'hFF;
    m0_rready = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1; m1_bready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst.s_arvalid", 64'(s_arvalid), 64'(0));
    chk("rst.s_awvalid", 64'(s_awvalid), 64'(0));
    chk("rst.s_rready", 64'(s_rready), 64'(0));
    chk("rst.m0_arready", 64'(m0_arready), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    rst = 1'b0;

    // Simultaneous pair straight out of reset: m0 then m1.
    ar_drive(1'b0, 1'b1, 32'h40, 4'h1, 8'h0);
    ar_drive(1'b1, 1'b1, 32'h80, 4'h2, 8'h0);
    rd_grant("pair0", 1'b0, 4'h1, 64'hA5A5_0000_0000_0008, lat);
    rd_grant("pair1", 1'b1, 4'h2, 64'hA5A5_0000_0000_0010, lat);

    // m0 alone, one-cycle AR latency; pointer then favours m1.
    ar_drive(1'b0, 1'b1, 32'h100, 4'h3, 8'h0);
    rd_grant("m0rd", 1'b0, 4'h3, 64'hA5A5_0000_0000_0020, lat);
    chk("m0rd.lat", 64'(lat), 64'(1));
    ar_drive(1'b0, 1'b1, 32'h40, 4'h4, 8'h0);
    ar_drive(1'b1, 1'b1, 32'h80, 4'h5, 8'h0);
    rd_grant("alt0", 1'b1, 4'h5, 64'hA5A5_0000_0000_0010, lat);
    rd_grant("alt1", 1'b0, 4'h4, 64'hA5A5_0000_0000_0008, lat);

    // Concurrent m0 write and m1 read of the same address.
    aw_drive(1'b0, 1'b1, 32'h200, 4'h5, 8'h0, 64'hDEADBEEF_CAFEF00D);
    ar_drive(1'b1, 1'b1, 32'h200, 4'h6, 8'h0);
    @(negedge aclk);
    chk("cc.awvalid", 64'(s_awvalid), 64'(1));
    chk("cc.arvalid", 64'(s_arvalid), 64'(1));
    chk("cc.awid", 64'(s_awid), 64'(5'h05));
    chk("cc.arid", 64'(s_arid), 64'(5'h16));
    chk("cc.wready", 64'(m0_wready), 64'(1));
    chk("cc.wdata", s_wdata, 64'hDEADBEEF_CAFEF00D);
    @(negedge aclk);
    aw_drive(1'b0, 1'b0, 32'h0, '0, 8'h0, 64'h0);
    ar_drive(1'b1, 1'b0, 32'h0, '0, 8'h0);
    chk("cc.bvalid", 64'(m0_bvalid), 64'(1));
    chk("cc.bid", 64'(m0_bid), 64'(5));
    chk("cc.rvalid", 64'(m1_rvalid), 64'(1));
    chk("cc.rdata_old", m1_rdata, 64'hA5A5_0000_0000_0040);
    chk("cc.err", 64'(err), 64'(0));
    @(negedge aclk);
    ar_drive(1'b1, 1'b1, 32'h200, 4'h7, 8'h0);
    rd_grant("raw", 1'b1, 4'h7, 64'hDEADBEEF_CAFEF00D, lat);

    // B withheld: err rises once the wait reaches TIMEOUT, then sticks.
    hold_b = 1'b1;
    aw_drive(1'b0, 1'b1, 32'h300, 4'h9, 8'h0, 64'h1234);
    @(negedge aclk);
    chk("to.awvalid", 64'(s_awvalid), 64'(1));
    @(negedge aclk);
    aw_drive(1'b0, 1'b0, 32'h0, '0, 8'h0, 64'h0);
    chk("to.err_start", 64'(err), 64'(0));
    repeat (TIMEOUT - 1) @(negedge aclk);
    chk("to.err_early", 64'(err), 64'(0));
    @(negedge aclk);
    chk("to.err_rise", 64'(err), 64'(1));
    repeat (5) @(negedge aclk);
    chk("to.err_sticky", 64'(err), 64'(1));
    chk("to.no_bvalid", 64'(m0_bvalid), 64'(0));
    hold_b = 1'b0;
    @(negedge aclk);
    chk("to.bvalid", 64'(m0_bvalid), 64'(1));
    chk("to.bid", 64'(m0_bid), 64'(9));
    @(negedge aclk);
    chk("to.bdone", 64'(m0_bvalid), 64'(0));

    // Reset pulse while a read sits in R_DATA.
    m0_rready = 1'b0;
    ar_drive(1'b0, 1'b1, 32'h100, 4'hA, 8'h0);
    repeat (2) @(negedge aclk);
    ar_drive(1'b0, 1'b0, 32'h0, '0, 8'h0);
    chk("rs.hold", 64'(m0_rvalid), 64'(1));
    rst = 1'b1;
    @(negedge aclk);
    rst = 1'b0; m0_rready = 1'b1;
    chk("rs.rvalid", 64'(m0_rvalid), 64'(0));
    chk("rs.s_arvalid", 64'(s_arvalid), 64'(0));
    chk("rs.s_rready", 64'(s_rready), 64'(0));
    chk("rs.awready", 64'(m0_awready), 64'(0));
    chk("rs.err", 64'(err), 64'(0));
    ar_drive(1'b1, 1'b1, 32'h80, 4'hB, 8'h0);
    rd_grant("rs.m1", 1'b1, 4'hB, 64'hA5A5_0000_0000_0010, lat);
    chk("rs.lat", 64'(lat), 64'(1));

    // Write pointer back at m0 after reset; m1 then issues a 4-beat AW.
    aw_drive(1'b0, 1'b1, 32'h20, 4'h1, 8'h0, 64'h11);
    aw_drive(1'b1, 1'b1, 32'h28, 4'hC, 8'h3, 64'h22);
    wr_grant("wp0", 1'b0, 4'h1, 1'b0);
    wr_grant("wp1", 1'b1, 4'hC, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
